// File: rtl/dadda_pkg.sv
// rtl/dadda_pkg.sv - product width constants shared by the Dadda multiplier blocks
package dadda_pkg;

    localparam int DADDA_N     = 8;
    localparam int DADDA_ROW_W = 2 * DADDA_N;
    localparam int DADDA_SPLIT = DADDA_ROW_W / 2;

endpackage

// File: rtl/cpa_slice.sv
// rtl/cpa_slice.sv - combinational W-bit carry-propagate slice: {co, s} = a + b + ci
module cpa_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    logic [W:0] total;

    assign total = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
    assign s_o   = total[W-1:0];
    assign co_o  = total[W];

endmodule

// File: rtl/dadda_cpa_pipe.sv
// rtl/dadda_cpa_pipe.sv - two-stage elastic carry-propagate adder resolving the compressor tree rows
module dadda_cpa_pipe
    import dadda_pkg::*;
#(
    parameter int WIDTH = DADDA_ROW_W,
    parameter int SPLIT = DADDA_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int HW = WIDTH - SPLIT;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [SPLIT-1:0] lo_q, lo_d;
    logic             c1_q, c1_d;
    logic [HW-1:0]    ha_q, hb_q;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [HW-1:0]    hi_s;
    logic             hi_co;
    logic             s1_ld;
    logic             s2_ld;

    cpa_slice #(.W(SPLIT)) u_lo (
        .a_i  (row_a[SPLIT-1:0]),
        .b_i  (row_b[SPLIT-1:0]),
        .ci_i (cin),
        .s_o  (lo_d),
        .co_o (c1_d)
    );

    cpa_slice #(.W(HW)) u_hi (
        .a_i  (ha_q),
        .b_i  (hb_q),
        .ci_i (c1_q),
        .s_o  (hi_s),
        .co_o (hi_co)
    );

    // in_ready looks only at flop state and out_ready, never at in_valid
    assign in_ready = !v1_q || !v2_q || out_ready;
    assign s1_ld    = in_valid && in_ready;
    assign s2_ld    = v1_q && (!v2_q || out_ready);
    assign sum_d    = {hi_co, hi_s, lo_q};

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (s1_ld) begin
            v1_d = 1'b1;
        end else if (s2_ld) begin
            v1_d = 1'b0;
        end
        if (s2_ld) begin
            v2_d = 1'b1;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            lo_q  <= '0;
            c1_q  <= 1'b0;
            ha_q  <= '0;
            hb_q  <= '0;
            sum_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (s1_ld) begin
                lo_q <= lo_d;
                c1_q <= c1_d;
                ha_q <= row_a[WIDTH-1:SPLIT];
                hb_q <= row_b[WIDTH-1:SPLIT];
            end
            if (s2_ld) begin
                sum_q <= sum_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_dadda_cpa_pipe.sv
// tb/tb_dadda_cpa_pipe.sv - self-checking bench for dadda_cpa_pipe
module tb_dadda_cpa_pipe;
    import dadda_pkg::*;

    localparam int W = DADDA_ROW_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] row_a = '0;
    logic [W-1:0] row_b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   sum;

    int tests = 0;
    int fails = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs[8];

    dadda_cpa_pipe #(.WIDTH(W), .SPLIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_a     (row_a),
        .row_b     (row_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [31:0] t;
        t = 32'(a) + 32'(b) + 32'(ci);
        return t[W:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        row_a = W'($urandom);
        row_b = W'($urandom);
        cin   = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard: every accepted input predicts one output, in order
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'(sum), 32'hDEAD_BEEF);
                else check("scoreboard", 32'(sum), 32'(exp_q.pop_front()));
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(row_a, row_b, cin));
                in_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
        vecs[2] = '{16'h7F01, 16'h7F00, 1'b0, 17'h0FE01};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
        vecs[6] = '{16'h0080, 16'h0080, 1'b0, 17'h00100};
        vecs[7] = '{16'h1234, 16'h8765, 1'b1, 17'h0999A};

        repeat (2) tick();
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_sum", 32'(sum), 0);
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 1);

        // Directed vectors with two-edge latency
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            row_a = vecs[i].a;
            row_b = vecs[i].b;
            cin   = vecs[i].ci;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("vec_early", 32'(out_valid), 0);
            tick();
            check("vec_valid", 32'(out_valid), 1);
            check("vec_sum", 32'(sum), 32'(vecs[i].exp));
            tick();
        end

        // Back-to-back stream
        base = out_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_data();
            check("b2b_in_ready", 32'(in_ready), 1);
            if (i >= 2) check("b2b_out_valid", 32'(out_valid), 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("b2b_count", 32'(out_cnt - base), 100);

        // Backpressure: fill, hold, drain
        out_ready = 1'b0;
        in_valid = 1'b1;
        row_a = 16'h1111; row_b = 16'h2222; cin = 1'b0;
        tick();
        row_a = 16'hF0F0; row_b = 16'h0F10; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_sum_stable", 32'(sum), 32'h03333);
            tick();
        end
        base = out_cnt;
        out_ready = 1'b1;
        tick();
        tick();
        check("bp_drain_count", 32'(out_cnt - base), 2);
        tick();
        check("bp_empty", 32'(out_valid), 0);

        // Random stall with scoreboard
        base = in_cnt;
        cyc = 0;
        while ((in_cnt - base) < 1000 && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            rand_data();
            tick();
            cyc++;
        end
        check("stall_accepts", 32'(in_cnt - base), 1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("stall_drained", 32'(exp_q.size()), 0);
        tick();
        check("stall_idle", 32'(out_valid), 0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        row_a = 16'hAAAA; row_b = 16'h5555; cin = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("rst_full", 32'(in_ready), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        exp_q.delete();
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_stale", 32'(out_valid), 0);
        end
        row_a = 16'h00FF; row_b = 16'h0001; cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_after_sum", 32'(sum), 32'h00100);
        tick();
        check("rst_after_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
